// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the debugger response-path UART word serializer:
// the serializer state encoding and the transmitter byte width.
package uart_dbg_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_END
    } ser_state_t;

endpackage

// File: rtl/uart_tx_word_ser_if.sv
// Word handshake between the debug controller (master) and the UART word
// serializer (slave). Signal names keep the serializer's port naming.
interface uart_tx_word_ser_if #(
    parameter int WORD_BYTES = 4
);
    import uart_dbg_pkg::*;

    logic                           i_Word_Valid;
    logic [BYTE_W*WORD_BYTES-1:0]   i_Word;
    logic                           o_Word_Ready;

    modport master (
        output i_Word_Valid,
        output i_Word,
        input  o_Word_Ready
    );

    modport slave (
        input  i_Word_Valid,
        input  i_Word,
        output o_Word_Ready
    );

endinterface

// File: rtl/uart_word_fifo.sv
// Small synchronous word FIFO feeding the serializer. Pointers wrap modulo
// WORD_DEPTH (power of two); a level counter one bit wider than the pointers
// tells full from empty. The head word is read combinationally from the
// register array so it is available the cycle after it was written.
module uart_word_fifo #(
    parameter int WORD_DEPTH = 4,
    parameter int WIDTH      = 32
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic [WIDTH-1:0]              din_i,
    output logic [WIDTH-1:0]              dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(WORD_DEPTH):0]   level_o
);
    localparam int PTR_W   = $clog2(WORD_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [WORD_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               doPush;
    logic               doPop;

    assign full_o  = (level_q == LEVEL_W'(WORD_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rdPtr_q];
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;

    // Next pointer and occupancy values; a refused push or pop leaves them alone.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
        if (doPush && !doPop)      level_d = level_q + 1'b1;
        else if (!doPush && doPop) level_d = level_q - 1'b1;
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents need no reset because the level gates every read.
    always_ff @(posedge i_Clock) begin
        if (doPush) mem_q[wrPtr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_word_ser.sv
// UART word serializer: buffers 32-bit debug response words and feeds them
// MSB byte first into a byte-wide UART transmitter, pacing each strobe off the
// transmitter's Active/Done flags.
// Optional feature macro: UART_TX_SER_CKSUM_EN appends an XOR checksum byte
// after the data bytes of every word.
module uart_tx_word_ser
    import uart_dbg_pkg::*;
#(
    parameter int WORD_DEPTH = 4,
    parameter int WORD_BYTES = 4
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_n,
    uart_tx_word_ser_if.slave             word_if,
    output logic                          o_Tx_DV,
    output logic [BYTE_W-1:0]             o_Tx_Byte,
    input  logic                          i_Tx_Active,
    input  logic                          i_Tx_Done,
    output logic [$clog2(WORD_DEPTH):0]   o_Level,
    output logic                          o_Busy
);
    localparam int WORD_W = BYTE_W * WORD_BYTES;
`ifdef UART_TX_SER_CKSUM_EN
    localparam int FRAME_LEN = WORD_BYTES + 1;
`else
    localparam int FRAME_LEN = WORD_BYTES;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    ser_state_t          state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [CNT_W-1:0]    count_q;
    logic                txDv_q;
    logic [BYTE_W-1:0]   txByte_q;
`ifdef UART_TX_SER_CKSUM_EN
    logic [BYTE_W-1:0]   acc_q;
`endif

    logic [WORD_W-1:0]   fifoDout;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                popWord;
    logic [BYTE_W-1:0]   topByte;

    uart_word_fifo #(
        .WORD_DEPTH (WORD_DEPTH),
        .WIDTH      (WORD_W)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .push_i  (word_if.i_Word_Valid),
        .pop_i   (popWord),
        .din_i   (word_if.i_Word),
        .dout_o  (fifoDout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .level_o (o_Level)
    );

    assign word_if.o_Word_Ready = !fifoFull;
    assign o_Tx_DV   = txDv_q;
    assign o_Tx_Byte = txByte_q;
    assign o_Busy    = !fifoEmpty || (state_q != S_IDLE);
    assign topByte   = shift_q[WORD_W-1 -: BYTE_W];

    // A word leaves the FIFO from idle, or straight from the end of the previous
    // frame so consecutive words run back to back without an idle bubble.
    always_comb begin
        popWord = 1'b0;
        if (!fifoEmpty) begin
            if (state_q == S_IDLE)
                popWord = 1'b1;
            else if (state_q == S_WAIT_END && !i_Tx_Active && count_q == '0)
                popWord = 1'b1;
        end
    end

    // Serializer FSM with registered strobe/byte; the strobe is high for exactly
    // the cycle after an issue because every other path clears it.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            count_q  <= '0;
            txDv_q   <= 1'b0;
            txByte_q <= '0;
`ifdef UART_TX_SER_CKSUM_EN
            acc_q    <= '0;
`endif
        end else begin
            txDv_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (popWord) begin
                        shift_q <= fifoDout;
                        count_q <= CNT_W'(FRAME_LEN);
`ifdef UART_TX_SER_CKSUM_EN
                        acc_q   <= '0;
`endif
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!i_Tx_Active && !i_Tx_Done) begin
                        txDv_q  <= 1'b1;
`ifdef UART_TX_SER_CKSUM_EN
                        if (count_q == CNT_W'(1)) begin
                            txByte_q <= acc_q;
                        end else begin
                            txByte_q <= topByte;
                            acc_q    <= acc_q ^ topByte;
                        end
`else
                        txByte_q <= topByte;
`endif
                        shift_q <= shift_q << BYTE_W;
                        count_q <= count_q - 1'b1;
                        state_q <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (i_Tx_Active) state_q <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (!i_Tx_Active) begin
                        if (count_q != '0) begin
                            state_q <= S_ISSUE;
                        end else if (popWord) begin
                            shift_q <= fifoDout;
                            count_q <= CNT_W'(FRAME_LEN);
`ifdef UART_TX_SER_CKSUM_EN
                            acc_q   <= '0;
`endif
                            state_q <= S_ISSUE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word_ser.sv
// Scoreboard bench for uart_tx_word_ser with a behavioural UART transmitter
// (4 clocks per bit, 10 bits per byte, Done held through cleanup and the
// first idle cycle). Words are turned into expected byte streams at accept
// time; a monitor pops and compares on every strobe.
module tb_uart_tx_word_ser;

    localparam int WORD_DEPTH   = 4;
    localparam int WORD_BYTES   = 4;
    localparam int CLKS_PER_BIT = 4;
    localparam int BYTE_CLKS    = CLKS_PER_BIT * 10;
`ifdef UART_TX_SER_CKSUM_EN
    localparam int FRAME_LEN = WORD_BYTES + 1;
`else
    localparam int FRAME_LEN = WORD_BYTES;
`endif

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        dutDv;
    logic [7:0]  dutByte;
    logic [2:0]  dutLevel;
    logic        dutBusy;

    logic        txStall = 1'b0;
    logic        txActive = 1'b0;
    logic        txDone = 1'b0;
    logic        txActiveIn;
    int          txState = 0;
    int          txTimer = 0;

    int          checks = 0;
    int          fails = 0;
    int          cycle = 0;
    int          strobeCount = 0;
    int          lastDvCycle = 0;
    int          acceptCycle = 0;
    logic        prevDv = 1'b0;
    logic        pendingActive = 1'b0;
    logic [7:0]  expQ [$];
    logic [31:0] words [6];

    assign txActiveIn = txActive | txStall;

    uart_tx_word_ser_if #(.WORD_BYTES(WORD_BYTES)) wordIf ();

    uart_tx_word_ser #(
        .WORD_DEPTH (WORD_DEPTH),
        .WORD_BYTES (WORD_BYTES)
    ) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rstN),
        .word_if     (wordIf),
        .o_Tx_DV     (dutDv),
        .o_Tx_Byte   (dutByte),
        .i_Tx_Active (txActiveIn),
        .i_Tx_Done   (txDone),
        .o_Level     (dutLevel),
        .o_Busy      (dutBusy)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural transmitter: never reset by the DUT's reset.
    always @(posedge clk) begin
        case (txState)
            0: begin
                txDone <= 1'b0;
                if (dutDv && !txStall) begin
                    txActive <= 1'b1;
                    txTimer  <= BYTE_CLKS;
                    txState  <= 1;
                end
            end
            1: begin
                if (txTimer == 1) begin
                    txActive <= 1'b0;
                    txDone   <= 1'b1;
                    txState  <= 2;
                end else begin
                    txTimer <= txTimer - 1;
                end
            end
            default: begin
                txDone  <= 1'b1;
                txState <= 0;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a word becomes its bytes MSB first, plus the XOR byte when enabled.
    task automatic pushExpected(input logic [31:0] w);
        logic [7:0] cks;
        logic [7:0] b;
        cks = 8'h00;
        for (int i = 0; i < WORD_BYTES; i++) begin
            b = 8'((w >> (8 * (WORD_BYTES - 1 - i))) & 32'hFF);
            expQ.push_back(b);
            cks = cks ^ b;
        end
`ifdef UART_TX_SER_CKSUM_EN
        expQ.push_back(cks);
`endif
    endtask

    // Offer one word and hold it until the handshake completes or the budget expires.
    task automatic applyStimulus(input logic [31:0] w, input int budget);
        int waited;
        waited = 0;
        @(negedge clk);
        wordIf.i_Word_Valid = 1'b1;
        wordIf.i_Word = w;
        while (!wordIf.o_Word_Ready && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (!wordIf.o_Word_Ready) begin
            checkOutput("acceptTimeout", 32'(waited), 32'(budget + 1));
            wordIf.i_Word_Valid = 1'b0;
        end else begin
            @(posedge clk);
            pushExpected(w);
            #1;
            acceptCycle = cycle;
            wordIf.i_Word_Valid = 1'b0;
        end
    endtask

    // Wait until every expected byte has been strobed and everything is idle.
    task automatic waitDrain(input string name, input int budget);
        int waited;
        waited = 0;
        while ((expQ.size() != 0 || dutBusy || txState != 0) && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, "_drained"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_busyLow"}, 32'(dutBusy), 32'd0);
    endtask

    // Strobe monitor: scoreboard compare, one-cycle width, transmitter idle, Active follows.
    always @(negedge clk) begin
        if (pendingActive) begin
            checkOutput("activeAfterStrobe", 32'(txActiveIn), 32'd1);
            pendingActive = 1'b0;
        end
        if (dutDv) begin
            checkOutput("strobeWidth", 32'(prevDv), 32'd0);
            checkOutput("strobeWhileTxBusy", {30'd0, txActiveIn, txDone}, 32'd0);
            checkOutput("strobeHasExpected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("txByte", 32'(dutByte), 32'(expQ.pop_front()));
            strobeCount++;
            lastDvCycle = cycle;
            pendingActive = 1'b1;
        end
        prevDv = dutDv;
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int waited;
        int busyLow;

        wordIf.i_Word_Valid = 1'b0;
        wordIf.i_Word = '0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        checkOutput("rst_dv", 32'(dutDv), 32'd0);
        checkOutput("rst_byte", 32'(dutByte), 32'd0);
        checkOutput("rst_level", 32'(dutLevel), 32'd0);
        checkOutput("rst_busy", 32'(dutBusy), 32'd0);
        checkOutput("rst_ready", 32'(wordIf.o_Word_Ready), 32'd1);
        rstN = 1'b1;
        repeat (2) @(negedge clk);

        // Single word: byte order, latency of two cycles, frame length.
        $display("[TB] single word 0xDEADBEEF");
        base = strobeCount;
        applyStimulus(32'hDEADBEEF, 20);
        waited = 0;
        while (strobeCount == base && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("firstStrobeLatency", 32'(lastDvCycle - acceptCycle), 32'd2);
        waitDrain("single", 2000);
        checkOutput("singleStrobeCount", 32'(strobeCount - base), 32'(FRAME_LEN));

        // Fill while the transmitter is stalled; one word sits in the shift register.
        $display("[TB] fill with stalled transmitter");
        for (int i = 0; i < 6; i++) words[i] = $urandom;
        txStall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(words[i], 20);
            if (i == 3) begin
                checkOutput("fill4_level", 32'(dutLevel), 32'd3);
                checkOutput("fill4_ready", 32'(wordIf.o_Word_Ready), 32'd1);
            end
        end
        checkOutput("full_level", 32'(dutLevel), 32'd4);
        checkOutput("full_ready", 32'(wordIf.o_Word_Ready), 32'd0);
        fork
            applyStimulus(words[5], 1000);
            begin
                repeat (10) @(negedge clk);
                checkOutput("fullRefuses_level", 32'(dutLevel), 32'd4);
                checkOutput("fullRefuses_ready", 32'(wordIf.o_Word_Ready), 32'd0);
                txStall = 1'b0;
            end
        join
        waitDrain("fill", 4000);

        // Random words with random gaps.
        $display("[TB] random words");
        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom, 400);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        waitDrain("random", 3000);

        // Reset during the second byte: queue and partial word are discarded.
        $display("[TB] reset mid-word");
        base = strobeCount;
        applyStimulus(32'h11223344, 20);
        waited = 0;
        while (strobeCount < base + 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reachedByte2", 32'(strobeCount - base), 32'd2);
        repeat (10) @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("midRst_dv", 32'(dutDv), 32'd0);
        checkOutput("midRst_byte", 32'(dutByte), 32'd0);
        checkOutput("midRst_level", 32'(dutLevel), 32'd0);
        checkOutput("midRst_busy", 32'(dutBusy), 32'd0);
        checkOutput("midRst_ready", 32'(wordIf.o_Word_Ready), 32'd1);
        expQ.delete();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(32'hA5A5A5A5, 20);
        waitDrain("afterReset", 2000);

        // Two-word stream: busy stays high until the last byte completes.
        $display("[TB] two-word stream");
        base = strobeCount;
        busyLow = 0;
        applyStimulus(32'h01020304, 20);
        applyStimulus(32'h05060708, 20);
        waited = 0;
        while (!(strobeCount >= base + 2 * FRAME_LEN && !txActiveIn) && waited < 2000) begin
            @(negedge clk);
            if (!dutBusy) busyLow++;
            waited++;
        end
        checkOutput("streamStrobes", 32'(strobeCount - base), 32'(2 * FRAME_LEN));
        checkOutput("busyThroughout", 32'(busyLow), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("streamBusyFalls", 32'(dutBusy), 32'd0);
        checkOutput("streamLevel", 32'(dutLevel), 32'd0);
        waitDrain("stream", 200);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
